// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if
//
// Bundles the program-load handshake, the instruction-memory write port and
// the loader status flags into one interface.
//
//   master : program source / bench side. Drives start and the instruction
//            fields; observes in_ready, the write port and the status flags.
//   slave  : the loader itself (instr_mem_loader).
//
// Signals
//   start        begin a new program load (restarts address and count)
//   in_valid     instruction fields valid
//   in_ready     loader accepts fields this cycle
//   in_last      final instruction of the program
//   in_kind      0=load-I 1=ALU-I 2=S 3=R 4=B 5=J 6/7=illegal
//   in_rd/rs1/rs2, in_func3, in_func7   register and function fields
//   in_imm       signed immediate (byte offset for B/J)
//   imem_we      one-cycle write strobe
//   imem_addr    byte address of the write
//   imem_wdata   encoded RV32I word
//   count        words written since the last start
//   busy, done, full, err   status flags
// ---------------------------------------------------------------------------
interface instr_mem_loader_if #(
    parameter int DEPTH_LOG2 = 6
);
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [2:0]            in_kind;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_func3;
    logic [6:0]            in_func7;
    logic signed [31:0]    in_imm;
    logic                  imem_we;
    logic [31:0]           imem_addr;
    logic [31:0]           imem_wdata;
    logic [DEPTH_LOG2:0]   count;
    logic                  busy;
    logic                  done;
    logic                  full;
    logic                  err;

    modport master (
        output start, in_valid, in_last, in_kind, in_rd, in_rs1, in_rs2,
               in_func3, in_func7, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, count,
               busy, done, full, err
    );

    modport slave (
        input  start, in_valid, in_last, in_kind, in_rd, in_rs1, in_rs2,
               in_func3, in_func7, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata, count,
               busy, done, full, err
    );
endinterface

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Accepts decoded instruction fields one beat at a time, encodes each beat
// into a 32-bit RV32I word and writes it into instruction memory at
// consecutive word addresses starting at BASE_ADDR.
//
// Ports
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   instr_mem_loader_if.slave (handshake, write port, status)
//
// Flow: IDLE --start--> ACCEPT --beat--> WRITE --> ACCEPT (or DONE on last).
// One word is written every two cycles. Illegal beats (kind 6/7, or B/J with
// an odd offset) are consumed without a write and set the sticky err flag.
// When count reaches 2**DEPTH_LOG2 the loader stops accepting until start.
// start in any state restarts the load; rst takes priority over start.
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int          DEPTH_LOG2 = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    instr_mem_loader_if.slave   bus
);

    localparam int                CNT_W   = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(2 ** DEPTH_LOG2);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   count_q;
    logic               err_q;
    logic               last_p1;
    logic [31:0]        addr_p1;
    logic [31:0]        wdata_p1;

    logic               full_w;
    logic               ready_w;
    logic               accept_w;
    logic               legal_w;
    logic               wr_fire_w;
    logic               imem_we_w;
    logic               busy_w;
    logic               done_w;

    // -----------------------------------------------------------------------
    // A beat is legal when its kind has an encoding and, for B/J, the byte
    // offset is even (bit 0 cannot be represented in those formats).
    // -----------------------------------------------------------------------
    function automatic logic beat_legal(
        input logic [2:0]         kind,
        input logic signed [31:0] imm
    );
        logic ok;
        ok = 1'b1;
        if (kind > 3'd5) begin
            ok = 1'b0;
        end else if ((kind == 3'd4 || kind == 3'd5) && imm[0]) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // -----------------------------------------------------------------------
    // RV32I encoder. Immediate bits above each format's range are dropped.
    // -----------------------------------------------------------------------
    function automatic logic [31:0] encode(
        input logic [2:0]         kind,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic [2:0]         func3,
        input logic [6:0]         func7,
        input logic signed [31:0] imm
    );
        logic [31:0] word;
        case (kind)
            3'd0:    word = {imm[11:0], rs1, func3, rd, OP_LOAD};
            3'd1:    word = {imm[11:0], rs1, func3, rd, OP_ALU_I};
            3'd2:    word = {imm[11:5], rs2, rs1, func3, imm[4:0], OP_STORE};
            3'd3:    word = {func7, rs2, rs1, func3, rd, OP_ALU_R};
            3'd4:    word = {imm[12], imm[10:5], rs2, rs1, func3,
                             imm[4:1], imm[11], OP_BRANCH};
            3'd5:    word = {imm[20], imm[10:1], imm[11], imm[19:12],
                             rd, OP_JAL};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    // Handshake and status decode shared by the FSM and datapath.
    assign full_w    = (count_q == CNT_MAX);
    assign ready_w   = (state == ACCEPT) && !full_w;
    assign accept_w  = bus.in_valid && ready_w;
    assign legal_w   = beat_legal(bus.in_kind, bus.in_imm);
    // A concurrent start cancels the pending write.
    assign wr_fire_w = (state == WRITE) && !bus.start;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. start overrides whatever the state was doing,
    // including a beat offered in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (bus.start) begin
            state_nxt = ACCEPT;
        end else begin
            case (state)
                IDLE:   state_nxt = IDLE;
                ACCEPT: begin
                    if (accept_w) begin
                        if (legal_w) begin
                            state_nxt = WRITE;
                        end else if (bus.in_last) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = ACCEPT;
                        end
                    end
                end
                WRITE:  state_nxt = last_p1 ? DONE : ACCEPT;
                DONE:   state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: output logic. The write strobe is gated by rst so a reset landing
    // in the WRITE cycle aborts the write immediately.
    // -----------------------------------------------------------------------
    always_comb begin
        imem_we_w = 1'b0;
        busy_w    = 1'b0;
        done_w    = 1'b0;
        case (state)
            ACCEPT: busy_w = 1'b1;
            WRITE: begin
                busy_w    = 1'b1;
                imem_we_w = wr_fire_w && !rst;
            end
            DONE:   done_w = 1'b1;
            default: begin
                busy_w = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers: word count and sticky error.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (bus.start) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (wr_fire_w) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (accept_w && !legal_w) begin
                err_q <= 1'b1;
            end
        end
    end

    // ---- stage p1: accepted beat encoded and registered for the write ----
    // Address and data hold their last values whenever no legal beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_p1  <= BASE_ADDR;
            wdata_p1 <= 32'h0000_0000;
            last_p1  <= 1'b0;
        end else if (accept_w && !bus.start) begin
            last_p1 <= bus.in_last;
            if (legal_w) begin
                addr_p1  <= BASE_ADDR + (32'(count_q) << 2);
                wdata_p1 <= encode(bus.in_kind, bus.in_rd, bus.in_rs1,
                                   bus.in_rs2, bus.in_func3, bus.in_func7,
                                   bus.in_imm);
            end
        end
    end

    assign bus.in_ready   = ready_w;
    assign bus.imem_we    = imem_we_w;
    assign bus.imem_addr  = addr_p1;
    assign bus.imem_wdata = wdata_p1;
    assign bus.count      = count_q;
    assign bus.busy       = busy_w;
    assign bus.done       = done_w;
    assign bus.full       = full_w;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Directed beats for the documented encodings plus randomized programs.
// Expected writes go into a scoreboard queue when a beat is handed over; an
// independent monitor pops and compares on every imem_we. Status flags are
// compared against a small program-level model (count, err, done).
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int          DL2  = 2;
    localparam int          CAP  = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.DEPTH_LOG2(DL2)) bus ();

    instr_mem_loader #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          passes = 0;

    // Program-level reference state
    int          m_count;
    bit          m_err;
    bit          m_done;
    bit          use_dir;
    logic [31:0] dir_word;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference encoder built from shifted and masked fields.
    function automatic logic [31:0] ref_encode(input int kind, input int rd,
        input int rs1, input int rs2, input int f3, input int f7,
        input logic [31:0] imm);
        logic [31:0] op [6];
        logic [31:0] w;
        logic [31:0] r_rd, r_rs1, r_rs2, r_f3, r_f7;
        op[0] = 32'h03; op[1] = 32'h13; op[2] = 32'h23;
        op[3] = 32'h33; op[4] = 32'h63; op[5] = 32'h6F;
        r_rd = 32'(rd); r_rs1 = 32'(rs1); r_rs2 = 32'(rs2);
        r_f3 = 32'(f3); r_f7 = 32'(f7);
        w = 32'h0;
        case (kind)
            0, 1: w = ((imm & 32'hFFF) << 20) | (r_rs1 << 15) | (r_f3 << 12)
                      | (r_rd << 7) | op[kind];
            2:    w = (((imm >> 5) & 32'h7F) << 25) | (r_rs2 << 20)
                      | (r_rs1 << 15) | (r_f3 << 12) | ((imm & 32'h1F) << 7)
                      | op[2];
            3:    w = (r_f7 << 25) | (r_rs2 << 20) | (r_rs1 << 15)
                      | (r_f3 << 12) | (r_rd << 7) | op[3];
            4:    w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                      | (r_rs2 << 20) | (r_rs1 << 15) | (r_f3 << 12)
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7)
                      | op[4];
            5:    w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | (r_rd << 7) | op[5];
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, no write expected",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", bus.imem_addr, e.addr);
                check("write_data", bus.imem_wdata, e.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        m_count = 0;
        m_err   = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        model_clear();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'(m_count));
        check({tag, "_err"},   32'(bus.err),   32'(m_err));
        check({tag, "_done"},  32'(bus.done),  32'(m_done));
        check({tag, "_full"},  32'(bus.full),  32'(m_count == CAP));
    endtask

    // Offer one beat; with abort set, rst is raised during the WRITE cycle.
    task automatic send_beat(input int kind, input int rd, input int rs1,
        input int rs2, input int f3, input int f7, input logic [31:0] imm,
        input bit last, input bit abort);
        int  waited;
        bit  got;
        bit  legal;
        wr_t e;
        bus.in_kind  = 3'(kind);
        bus.in_rd    = 5'(rd);
        bus.in_rs1   = 5'(rs1);
        bus.in_rs2   = 5'(rs2);
        bus.in_func3 = 3'(f3);
        bus.in_func7 = 7'(f7);
        bus.in_imm   = imm;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 20) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                waited++;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL handshake_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (abort) begin
            rst = 1'b1;
            @(negedge clk);
            check("abort_we", 32'(bus.imem_we), 32'h0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            model_clear();
            return;
        end
        legal = (kind <= 5) && !((kind == 4 || kind == 5) && imm[0]);
        if (legal) begin
            e.addr = BASE + 32'(4 * m_count);
            e.data = use_dir ? dir_word : ref_encode(kind, rd, rs1, rs2, f3, f7, imm);
            exp_q.push_back(e);
            m_count++;
        end else begin
            m_err = 1'b1;
        end
        if (last) m_done = 1'b1;
        use_dir = 1'b0;
    endtask

    task automatic dir_beat(input logic [31:0] word, input int kind, input int rd,
        input int rs1, input int rs2, input int f3, input int f7,
        input logic [31:0] imm, input bit last);
        use_dir  = 1'b1;
        dir_word = word;
        send_beat(kind, rd, rs1, rs2, f3, f7, imm, last, 1'b0);
        use_dir  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.in_kind = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_func3 = '0; bus.in_func7 = '0; bus.in_imm = '0;
        use_dir = 1'b0; dir_word = '0;
        model_clear();

        // Reset state
        do_reset();
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_we",    32'(bus.imem_we), 32'h0);
        check("rst_addr",  bus.imem_addr, BASE);
        check("rst_wdata", bus.imem_wdata, 32'h0);
        check("rst_err",   32'(bus.err), 32'h0);
        check("rst_done",  32'(bus.done), 32'h0);
        check("rst_ready", 32'(bus.in_ready), 32'h0);
        check("rst_busy",  32'(bus.busy), 32'h0);

        // I-type encodings
        do_start();
        check("start_busy",  32'(bus.busy), 32'h1);
        check("start_ready", 32'(bus.in_ready), 32'h1);
        dir_beat(32'h0050_0093, 1, 1, 0, 0, 0, 0, 32'd5, 1'b0);
        dir_beat(32'h0080_A103, 0, 2, 1, 0, 2, 0, 32'd8, 1'b0);
        tick(1);
        check("i_count", 32'(bus.count), 32'd2);

        // S and B encodings
        do_start();
        dir_beat(32'h0020_A623, 2, 0, 1, 2, 2, 0, 32'd12, 1'b0);
        dir_beat(32'hFE20_8CE3, 4, 0, 1, 2, 0, 0, -32'sd8, 1'b0);
        tick(1);
        check_status("sb");

        // R and J encodings, last beat ends the program
        do_start();
        dir_beat(32'h0020_81B3, 3, 3, 1, 2, 0, 0, 32'd0, 1'b0);
        dir_beat(32'h0100_00EF, 5, 1, 0, 0, 0, 0, 32'd16, 1'b1);
        tick(1);
        check("rj_done",  32'(bus.done), 32'h1);
        check("rj_ready", 32'(bus.in_ready), 32'h0);
        check("rj_busy",  32'(bus.busy), 32'h0);
        tick(2);
        check_status("rj_hold");

        // Illegal beats: consumed, no write, sticky err
        do_start();
        send_beat(1, 4, 5, 0, 0, 0, 32'd7, 1'b0, 1'b0);
        send_beat(7, 1, 1, 1, 0, 0, 32'd4, 1'b0, 1'b0);
        send_beat(4, 0, 1, 2, 0, 0, 32'd3, 1'b0, 1'b0);
        tick(1);
        check_status("illegal");
        do_start();
        check_status("illegal_clr");

        // Capacity: four writes fill the memory, the fifth beat stalls
        do_start();
        for (int i = 0; i < CAP; i++)
            send_beat(1, i + 1, 0, 0, 0, 0, 32'(i * 3), 1'b0, 1'b0);
        tick(1);
        check_status("full");
        bus.in_valid = 1'b1;
        bus.in_kind  = 3'd1;
        tick(3);
        @(negedge clk);
        check("full_stall_ready", 32'(bus.in_ready), 32'h0);
        check("full_stall_busy",  32'(bus.busy), 32'h1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("full_stall_count", 32'(bus.count), 32'(CAP));

        // Reset during the WRITE cycle
        do_start();
        send_beat(1, 1, 0, 0, 0, 0, 32'd5, 1'b0, 1'b0);
        send_beat(3, 7, 2, 3, 1, 0, 32'd0, 1'b0, 1'b1);
        check("abort_count", 32'(bus.count), 32'h0);
        check("abort_addr",  bus.imem_addr, BASE);
        check("abort_wdata", bus.imem_wdata, 32'h0);
        check("abort_busy",  32'(bus.busy), 32'h0);
        check("abort_ready", 32'(bus.in_ready), 32'h0);
        bus.in_valid = 1'b1;
        tick(2);
        check("abort_no_resume", 32'(bus.in_ready), 32'h0);
        bus.in_valid = 1'b0;

        // Randomized programs
        for (int p = 0; p < 30; p++) begin
            int len;
            do_start();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                int          kind;
                logic [31:0] imm;
                if (m_count == CAP) break;
                kind = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 7)
                                                   : $urandom_range(0, 5);
                imm  = $urandom;
                if ((kind == 4 || kind == 5) && $urandom_range(0, 3) != 0)
                    imm[0] = 1'b0;
                send_beat(kind, $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 7),
                          $urandom_range(0, 127), imm, i == len - 1, 1'b0);
            end
            tick(1);
            check_status("rand");
        end

        tick(2);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
